// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port synchronous dmem between port A (CPU, priority) and port B
// (loader/debug DMA, starvation guard + lock). Define DMEM_ARB_STATS_EN to add saturating statistics counters.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_WAIT     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_wren,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_wren,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_conflicts,
  output logic [15:0]       stat_forced
`endif
);

  typedef enum logic [1:0] {IDLE, OWN_A, LOCK_B} state_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_e                  state_q, state_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0] pipe_own_b_q, pipe_own_b_d;
  logic [DATA_W-1:0]       a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]       b_rdata_q, b_rdata_d;
  logic                    forced;
  logic                    rd_push;

  always_comb begin : arbitrate
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    forced = 1'b0;
    a_gnt  = 1'b0;
    b_gnt  = 1'b0;
    if (state_q == LOCK_B) begin
      b_gnt = b_req;
    end else begin
      forced = b_req && (wait_cnt_q == MAX_WAIT_C);
      b_gnt  = forced || (b_req && !a_req);
      a_gnt  = a_req && !forced;
    end
  end

  always_comb begin : dmem_mux
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    if (a_gnt) begin
      address_dmem = a_addr;
      data         = a_wdata;
      wren         = a_wren;
    end else if (b_gnt) begin
      address_dmem = b_addr;
      data         = b_wdata;
      wren         = b_wren;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      LOCK_B: begin
        // In LOCK_B b_req implies b_gnt, so this covers both "unlocked beat" and "request dropped".
        if (!b_req || !b_lock) state_d = IDLE;
      end
      default: begin
        if (b_gnt && b_lock) state_d = LOCK_B;
        else if (a_gnt)      state_d = OWN_A;
        else                 state_d = IDLE;
      end
    endcase

    wait_cnt_d = '0;
    if (b_req && !b_gnt)
      wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 4'd1;
  end

  always_comb begin : read_pipe
    rd_push         = (a_gnt && !a_wren) || (b_gnt && !b_wren);
    pipe_vld_d      = '0;
    pipe_own_b_d    = '0;
    pipe_vld_d[0]   = rd_push;
    pipe_own_b_d[0] = b_gnt;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i]   = pipe_vld_q[i-1];
      pipe_own_b_d[i] = pipe_own_b_q[i-1];
    end

    a_rvalid  = pipe_vld_q[READ_LATENCY-1] && !pipe_own_b_q[READ_LATENCY-1];
    b_rvalid  = pipe_vld_q[READ_LATENCY-1] &&  pipe_own_b_q[READ_LATENCY-1];
    // Read data is forwarded straight from q_dmem in the rvalid cycle and held afterwards.
    a_rdata_d = a_rvalid ? q_dmem : a_rdata_q;
    b_rdata_d = b_rvalid ? q_dmem : b_rdata_q;
    a_rdata   = a_rdata_d;
    b_rdata   = b_rdata_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      // NOTE: the read pipe is reset, not left as uninitialised storage: stale entries would fire rvalid.
      pipe_vld_q   <= '0;
      pipe_own_b_q <= '0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_own_b_q <= pipe_own_b_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_conflicts_q, stat_conflicts_d;
  logic [15:0] stat_forced_q, stat_forced_d;

  always_comb begin : stats_next
    stat_conflicts_d = stat_conflicts_q;
    stat_forced_d    = stat_forced_q;
    if (a_req && b_req && !(&stat_conflicts_q)) stat_conflicts_d = stat_conflicts_q + 16'd1;
    if (forced && !(&stat_forced_q))            stat_forced_d    = stat_forced_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_conflicts_q <= '0;
      stat_forced_q    <= '0;
    end else begin
      stat_conflicts_q <= stat_conflicts_d;
      stat_forced_q    <= stat_forced_d;
    end
  end

  assign stat_conflicts = stat_conflicts_q;
  assign stat_forced    = stat_forced_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: vector table of requests/expected grants, with a
// read-return scoreboard fed from a bench-side shadow of dmem contents.
module tb_dmem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int RL = 1;
  localparam int MW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          a_req, a_wren, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_wren, b_lock, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [AW-1:0] address_dmem;
  logic [DW-1:0] data, q_dmem;
  logic          wren;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   stat_conflicts, stat_forced;
`endif

  always #5 clock = ~clock;

  dmem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .MAX_WAIT(MW)
  ) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_wren(a_wren), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wren(b_wren), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
`ifdef DMEM_ARB_STATS_EN
    , .stat_conflicts(stat_conflicts), .stat_forced(stat_forced)
`endif
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 'h010) ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(i));
  endfunction

  // Synchronous dmem with RL-cycle read latency; preloads itself on its first clock.
  logic [DW-1:0] dmem  [0:(1<<AW)-1];
  logic [DW-1:0] q_pipe[RL];
  bit            mem_loaded = 1'b0;

  always @(posedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < (1 << AW); i++) dmem[i] <= init_val(i);
      mem_loaded <= 1'b1;
    end else begin
      q_pipe[0] <= dmem[address_dmem];
      for (int i = 1; i < RL; i++) q_pipe[i] <= q_pipe[i-1];
      if (wren) dmem[address_dmem] <= data;
    end
  end
  assign q_dmem = q_pipe[RL-1];

  typedef struct {
    logic          a_req;
    logic          a_wren;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          b_req;
    logic          b_wren;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_lock;
    logic          exp_a;
    logic          exp_b;
  } vec_t;

  typedef struct {
    logic          own_b;
    logic [DW-1:0] val;
    int            due;
  } sb_t;

  sb_t           sb[$];
  vec_t          vecs[$];
  logic [DW-1:0] shadow[0:(1<<AW)-1];
  logic [DW-1:0] exp_a_rdata = '0;
  logic [DW-1:0] exp_b_rdata = '0;
  int            errors = 0;
  int            checks = 0;
  int            cyc    = 0;
  int            n_phase1;

  function automatic vec_t mk(input logic ar, input logic aw, input logic [AW-1:0] aa,
                              input logic [DW-1:0] ad, input logic br, input logic bw,
                              input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                              input logic bl, input logic ea, input logic eb);
    vec_t v;
    v.a_req = ar; v.a_wren = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_wren = bw; v.b_addr = ba; v.b_wdata = bd; v.b_lock = bl;
    v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  function automatic vec_t idle_v();
    return mk(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a_req = v.a_req; a_wren = v.a_wren; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_req = v.b_req; b_wren = v.b_wren; b_addr = v.b_addr; b_wdata = v.b_wdata;
    b_lock = v.b_lock;
  endtask

  // One cycle: drive just after the edge, check at the falling edge, update model, advance.
  task automatic step(input vec_t v);
    logic          exp_av, exp_bv;
    logic [44:0]   exp_out;
    sb_t           e;
    drive(v);
    @(negedge clock);
    exp_av = 1'b0;
    exp_bv = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.own_b) begin exp_bv = 1'b1; exp_b_rdata = e.val; end
      else         begin exp_av = 1'b1; exp_a_rdata = e.val; end
    end
    check("rvalid{a,b}", {a_rvalid, b_rvalid}, {exp_av, exp_bv});
    check("a_rdata", a_rdata, exp_a_rdata);
    check("b_rdata", b_rdata, exp_b_rdata);
    check("gnt{a,b}", {a_gnt, b_gnt}, {v.exp_a, v.exp_b});
    if (v.exp_a)      exp_out = {v.a_addr, v.a_wdata, v.a_wren};
    else if (v.exp_b) exp_out = {v.b_addr, v.b_wdata, v.b_wren};
    else              exp_out = '0;
    check("dmem{addr,data,wren}", {address_dmem, data, wren}, exp_out);
    if (v.exp_a) begin
      if (v.a_wren) shadow[v.a_addr] = v.a_wdata;
      else begin e.own_b = 1'b0; e.val = shadow[v.a_addr]; e.due = cyc + RL; sb.push_back(e); end
    end else if (v.exp_b) begin
      if (v.b_wren) shadow[v.b_addr] = v.b_wdata;
      else begin e.own_b = 1'b1; e.val = shadow[v.b_addr]; e.due = cyc + RL; sb.push_back(e); end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " gnt/rvalid"}, {a_gnt, b_gnt, a_rvalid, b_rvalid}, '0);
    check({name, " a_rdata"}, a_rdata, '0);
    check({name, " b_rdata"}, b_rdata, '0);
    check({name, " dmem"}, {address_dmem, data, wren}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) shadow[i] = init_val(i);
    drive(idle_v());
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Phase 1: single A read, then 10 conflict cycles (A reads, B writes) showing the 4:1 pattern.
    vecs.push_back(idle_v());
    vecs.push_back(mk(1, 0, 12'h010, '0, 0, 0, '0, '0, 0, 1, 0));
    vecs.push_back(idle_v());
    vecs.push_back(idle_v());
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(1, 0, 12'h030, '0, 1, 1, 12'h040, 32'hB0B0_0001, 0,
                        (k % 5) != 4, (k % 5) == 4));
    vecs.push_back(idle_v());
    n_phase1 = vecs.size();

    // Phase 2: B write visible to A; B lock with unlocked read beat; lock dropped by b_req=0;
    // A then B reads on adjacent cycles; write-after-read on the same address.
    vecs.push_back(mk(1, 0, 12'h040, '0, 0, 0, '0, '0, 0, 1, 0));
    vecs.push_back(mk(0, 0, '0, '0, 1, 1, 12'h020, 32'h0000_0055, 1, 0, 1));
    vecs.push_back(mk(1, 0, 12'h050, '0, 1, 0, 12'h020, '0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 12'h050, '0, 0, 0, '0, '0, 0, 1, 0));
    vecs.push_back(idle_v());
    vecs.push_back(mk(0, 0, '0, '0, 1, 1, 12'h070, 32'h7777_0070, 1, 0, 1));
    vecs.push_back(mk(1, 0, 12'h070, '0, 0, 0, '0, '0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 12'h070, '0, 0, 0, '0, '0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 12'h010, '0, 0, 0, '0, '0, 0, 1, 0));
    vecs.push_back(mk(0, 0, '0, '0, 1, 0, 12'h030, '0, 0, 0, 1));
    vecs.push_back(idle_v());
    vecs.push_back(mk(1, 0, 12'h080, '0, 0, 0, '0, '0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 12'h080, 32'h1234_5678, 0, 0, '0, '0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 12'h080, '0, 0, 0, '0, '0, 0, 1, 0));
    vecs.push_back(idle_v());
    vecs.push_back(idle_v());

    for (int i = 0; i < n_phase1; i++) step(vecs[i]);
`ifdef DMEM_ARB_STATS_EN
    check("stat_conflicts", stat_conflicts, 16'd10);
    check("stat_forced", stat_forced, 16'd2);
`endif
    for (int i = n_phase1; i < vecs.size(); i++) step(vecs[i]);

    // Reset one cycle after an accepted (locked) B read: read dropped, lock released.
    step(mk(0, 0, '0, '0, 1, 0, 12'h060, '0, 1, 0, 1));
    drive(idle_v());
    reset = 1'b0;
    #1;
    check_all_zero("mid-reset");
    sb.delete();
    exp_a_rdata = '0;
    exp_b_rdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    step(idle_v());
    step(idle_v());
    step(mk(1, 0, 12'h010, '0, 1, 0, 12'h020, '0, 0, 1, 0));
    step(idle_v());
    step(idle_v());
    check("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port synchronous dmem between two requesters: port A, the processor, and port B, the program loader / debug DMA.
- Sits between those requesters and the dmem instance in the top-level wrapper, and drives dmem address, data and wren.
- Fixed priority to A, with a starvation guard and a lock for B. Read data is returned to the owner after a fixed latency, tagged by pipeline.

Parameters:
ADDR_W, 12, dmem address width
DATA_W, 32, dmem data width
READ_LATENCY, 1, clock cycles from an accepted read to q_dmem valid (legal 1..3)
MAX_WAIT, 4, consecutive denied cycles of B before B is forced to win (legal 1..15)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
a_req  in  1  port A request this cycle
a_wren  in  1  port A write (1) / read (0)
a_addr  in  ADDR_W  port A address
a_wdata  in  DATA_W  port A write data
a_gnt  out  1  port A transaction accepted this cycle
a_rvalid  out  1  port A read data valid
a_rdata  out  DATA_W  port A read data
b_req  in  1  port B request
b_wren  in  1  port B write / read
b_addr  in  ADDR_W  port B address
b_wdata  in  DATA_W  port B write data
b_lock  in  1  port B requests to keep ownership after this beat
b_gnt  out  1  port B accepted
b_rvalid  out  1  port B read data valid
b_rdata  out  DATA_W  port B read data
address_dmem  out  ADDR_W  to dmem
data  out  DATA_W  to dmem
wren  out  1  to dmem write enable
q_dmem  in  DATA_W  from dmem

Behaviour:
- Reset (reset=0, asynchronous):
  - all registered state cleared: FSM=IDLE, wait_cnt=0, read pipe empty.
  - a_rvalid=b_rvalid=0; a_rdata=b_rdata=0.
- Grants and dmem outputs are combinational from registered state and the current requests. a_gnt and b_gnt are one-hot or both 0.
- Transaction semantics:
  - a transaction is accepted when req & gnt are high in the same cycle.
  - the requester holds its request until granted.
  - one beat per accepted cycle.
- dmem outputs:
  - driven from the winner's addr/wdata/wren.
  - with no winner: address_dmem=0, data=0, wren=0.
- FSM states and winner selection:
  - IDLE/OWN_A: winner priority is A, unless wait_cnt==MAX_WAIT, in which case B wins if b_req.
  - LOCK_B: B wins whenever b_req; A is denied.
    - Exit to IDLE when B is accepted with b_lock=0, or when b_req=0 for one cycle.
  - Enter LOCK_B when B is accepted with b_lock=1.
- Starvation counter (wait_cnt, saturating):
  - increments when b_req & !b_gnt.
  - clears on b_gnt or !b_req.
  - A is never starved by the guard: at most 1 forced B beat per MAX_WAIT+1 cycles outside a lock.
- Read return pipeline:
  - each accepted read pushes {valid, owner} into a READ_LATENCY-deep shift pipe.
  - at the output, owner's rvalid=1 for exactly one cycle, and owner's rdata is loaded from q_dmem.
  - rdata holds its value until the next rvalid for that port.
- Writes never produce rvalid; write-after-read on consecutive cycles is legal.
- Simultaneous a_req & b_req:
  - A wins (IDLE, wait_cnt<MAX_WAIT); B wins (forced or LOCK_B).
  - the loser's gnt=0 and no state is lost.
- Reset mid-operation: in-flight reads are dropped, with no rvalid after reset release. The lock is released.
- Back-to-back accepted reads produce back-to-back rvalid pulses in order.

Optional Feature:
- Macro DMEM_ARB_STATS_EN:
  - when defined, adds outputs stat_conflicts (16 bit, counts cycles with a_req & b_req) and stat_forced (16 bit, counts forced B grants).
  - both counters are saturating and cleared by reset.
- Without the macro: these ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- After reset release, A reads addr 0x010 (dmem holds 0xDEADBEEF) -> a_gnt=1 in that cycle; a_rvalid=1 exactly READ_LATENCY cycles later with a_rdata=0xDEADBEEF; b_rvalid stays 0.
- a_req and b_req both held high continuously, MAX_WAIT=4 -> A granted 4 cycles, B granted on the 5th, pattern repeats; wren/address track the winner each cycle.
- B writes 0x55 to 0x020 with b_lock=1, then reads 0x020 with b_lock=0 while a_req=1 -> a_gnt=0 for both beats; b_rvalid with 0x00000055; A granted the next cycle.
- A reads at cycle N and B reads at N+1 -> a_rvalid at N+L and b_rvalid at N+1+L, each carrying its own address's data.
- reset asserted asynchronously one cycle after an accepted read -> no rvalid after release; all outputs 0; FSM in IDLE (A wins the next conflict).
- With DMEM_ARB_STATS_EN, 10 conflict cycles with MAX_WAIT=4 -> stat_conflicts=10, stat_forced=2.
